// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state and grant encodings for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam gnt_e PRIO_RESET = GNT_D;

    function automatic gnt_e other_port(input gnt_e g);
        return (g == GNT_I) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-request round-robin picker, priority moves only on an accepted grant
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i_i,
    input  logic req_d_i,
    input  logic update_i,
    output logic valid_o,
    output logic gnt_d_o
);

    gnt_e prio_q;
    gnt_e prio_d;
    gnt_e gnt;

    always_comb begin
        valid_o = req_i_i | req_d_i;
        gnt     = prio_q;
        if (req_i_i && !req_d_i) begin
            gnt = GNT_I;
        end else if (req_d_i && !req_i_i) begin
            gnt = GNT_D;
        end
        // The port just served loses the next tie.
        prio_d = prio_q;
        if (update_i && valid_o) begin
            prio_d = other_port(gnt);
        end
    end

    assign gnt_d_o = (gnt == GNT_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO_RESET;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises fetch and data port requests onto a single-port memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    state_e                state_q, state_d;
    gnt_e                  gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic arb_valid;
    logic arb_gnt_d;
    logic in_idle;

    assign in_idle = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i_i  (i_req),
        .req_d_i  (d_req),
        .update_i (in_idle),
        .valid_o  (arb_valid),
        .gnt_d_o  (arb_gnt_d)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        mem_addr  = addr_q;
        mem_data  = wdata_q;
        mem_we    = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (arb_gnt_d) begin
                        gnt_d   = GNT_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        gnt_d   = GNT_I;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                    // The grant cycle drives memory directly so a write lands this edge.
                    mem_addr = addr_d;
                    mem_data = wdata_d;
                    mem_we   = we_d;
                    state_d  = we_d ? ST_ACK : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (gnt_q == GNT_D) begin
                    d_rdata_d = mem_out;
                end else begin
                    i_rdata_d = mem_out;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                i_ack   = (gnt_q == GNT_I);
                d_ack   = (gnt_q == GNT_D);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
